// File: rtl/render_cmd_loader.sv
`default_nettype none
// ============================================================================
//  Module   : render_cmd_loader
//  Purpose  : Collects a variable-length draw packet from the byte-serial host
//             link into an operand register file, then hands control to the
//             draw engine until it reports completion.
//
//  Packet   : header h, n = h[CNT_W-1:0], followed by 2*(n+1) operand bytes
//             (L = 2n+3 bytes in total). A header of 0x00 is a NOP.
//
//  Ports    : ACLK        clock, rising edge
//             RESET       asynchronous, active-high reset
//             ENB         global draw enable, gates DRAW_GO
//             STATUS      start a packet session (level, sampled in IDLE)
//             RByte       host data byte
//             VALID       host byte strobe, one byte per low->high transition
//             DRAW_DONE   draw engine finished (level, sampled in DRAW)
//             REGS        register file, reg k at [k*DW +: DW], reg0 = header
//             DRAW_GO     ENB && state == DRAW
//             FinishRead  one-cycle pulse: packet complete
//             FinishWrite one-cycle pulse: draw complete
//             BUSY        state != IDLE
//             ERR         sticky read-timeout flag
//
//  Options  : define TIMEOUT_EN to abort a stalled packet after TO_CYC idle
//             cycles (sets ERR). Without it ERR is tied low and the loader
//             waits indefinitely.
//
//  Revision : 1.0  initial release
// ============================================================================
module render_cmd_loader #(
  parameter  int DW     = 8,
  parameter  int CNT_W  = 3,
  parameter  int TO_CYC = 1023,
  localparam int NREG   = 2**(CNT_W+1) + 1
) (
  input  logic               ACLK,
  input  logic               RESET,
  input  logic               ENB,
  input  logic               STATUS,
  input  logic [DW-1:0]      RByte,
  input  logic               VALID,
  input  logic               DRAW_DONE,
  output logic [NREG*DW-1:0] REGS,
  output logic               DRAW_GO,
  output logic               FinishRead,
  output logic               FinishWrite,
  output logic               BUSY,
  output logic               ERR
);

  localparam int IDXW = $clog2(NREG);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_CAPT    = 3'd3,
    ST_DRAW    = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [NREG-1:0][DW-1:0]    regs_q, regs_d;
  logic                       finish_read_q, finish_read_d;
  logic                       finish_write_q, finish_write_d;

`ifdef TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYC + 1);
  logic [TOW-1:0]             to_cnt_q, to_cnt_d;
  logic                       err_q, err_d;
`endif

  // Index of the final byte of the packet (L-1 = 2n+2), derived from the
  // stored header. Only meaningful once reg0 holds the current header, i.e.
  // for idx > 0; at idx 0 it can never match because L-1 >= 2.
  logic [CNT_W-1:0]           hdr_cnt_w;
  logic [IDXW-1:0]            last_idx_w;

  assign hdr_cnt_w  = regs_q[0][CNT_W-1:0];
  assign last_idx_w = IDXW'({hdr_cnt_w, 1'b0}) + IDXW'(2);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    regs_d         = regs_q;
    finish_read_d  = 1'b0;
    finish_write_d = 1'b0;
`ifdef TIMEOUT_EN
    err_d          = err_q;
    to_cnt_d       = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (STATUS) begin
          state_d = ST_ARM;
          idx_d   = '0;
`ifdef TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end

      // Wait for VALID to be seen low so a held-high strobe yields one byte.
      ST_ARM: begin
        if (!VALID) begin
          state_d = ST_WAIT_HI;
        end
      end

      // FinishRead is raised on the transition into CAPT so the registered
      // pulse lines up with the capture cycle of the final byte.
      ST_WAIT_HI: begin
        if (VALID) begin
          state_d       = ST_CAPT;
          finish_read_d = (idx_q != '0) && (idx_q == last_idx_w);
        end
      end

      ST_CAPT: begin
        regs_d[idx_q] = RByte;
        if ((idx_q == '0) && (RByte == '0)) begin
          // NOP header: reg0 is rewritten with 0, index is not advanced.
          state_d = ST_ARM;
        end else if ((idx_q != '0) && (idx_q == last_idx_w)) begin
          state_d = ST_DRAW;
          idx_d   = '0;
        end else begin
          state_d = ST_ARM;
          idx_d   = idx_q + IDXW'(1);
        end
      end

      ST_DRAW: begin
        if (DRAW_DONE) begin
          state_d        = ST_IDLE;
          finish_write_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

`ifdef TIMEOUT_EN
    // Only a packet already in progress can time out; an idle link before
    // the header is legal. A rising VALID in WAIT_HI takes precedence.
    if (((state_q == ST_ARM) || ((state_q == ST_WAIT_HI) && !VALID)) &&
        (idx_q != '0)) begin
      if (to_cnt_q == TOW'(TO_CYC - 1)) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + TOW'(1);
      end
    end
`endif
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      regs_q         <= '0;
      finish_read_q  <= 1'b0;
      finish_write_q <= 1'b0;
`ifdef TIMEOUT_EN
      to_cnt_q       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      regs_q         <= regs_d;
      finish_read_q  <= finish_read_d;
      finish_write_q <= finish_write_d;
`ifdef TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign REGS        = regs_q;
  assign DRAW_GO     = ENB && (state_q == ST_DRAW);
  assign FinishRead  = finish_read_q;
  assign FinishWrite = finish_write_q;
  assign BUSY        = (state_q != ST_IDLE);

`ifdef TIMEOUT_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_render_cmd_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_render_cmd_loader
//  Purpose  : Directed self-checking bench for render_cmd_loader (default
//             parameters: DW=8, CNT_W=3, 17 registers).
//  Revision : 1.0  initial release
// ============================================================================
module tb_render_cmd_loader;

  localparam int DW   = 8;
  localparam int NREG = 17;

  logic               clk;
  logic               rst;
  logic               enb;
  logic               status;
  logic [DW-1:0]      rbyte;
  logic               valid;
  logic               draw_done;
  logic [NREG*DW-1:0] regs;
  logic               draw_go;
  logic               finish_read;
  logic               finish_write;
  logic               busy;
  logic               err;

  int passed;
  int total;
  int fr_cnt;

  render_cmd_loader #(.DW(8), .CNT_W(3), .TO_CYC(1023)) dut (
    .ACLK        (clk),
    .RESET       (rst),
    .ENB         (enb),
    .STATUS      (status),
    .RByte       (rbyte),
    .VALID       (valid),
    .DRAW_DONE   (draw_done),
    .REGS        (regs),
    .DRAW_GO     (draw_go),
    .FinishRead  (finish_read),
    .FinishWrite (finish_write),
    .BUSY        (busy),
    .ERR         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts FinishRead pulses so packets can be checked for exactly one.
  initial fr_cnt = 0;
  always @(posedge clk) if (finish_read === 1'b1) fr_cnt <= fr_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Starts a session from IDLE; leaves the DUT in WAIT_HI.
  task automatic start_session();
    status = 1'b1;
    valid  = 1'b0;
    step();
    status = 1'b0;
    step();
  endtask

  // Sends one byte starting from WAIT_HI; checks the FinishRead pulse in the
  // capture cycle and, for the final byte, DRAW_GO on the following cycle.
  task automatic send_byte(input logic [7:0] b, input logic last);
    rbyte = b;
    valid = 1'b1;
    step();
    chk("finish_read_capt", finish_read, last);
    step();
    if (last) chk("draw_go_after_read", draw_go, enb);
    valid = 1'b0;
    step();
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    enb       = 1'b1;
    status    = 1'b0;
    rbyte     = '0;
    valid     = 1'b0;
    draw_done = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_regs", regs, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_draw_go", draw_go, 1'b0);
    chk("rst_fr", finish_read, 1'b0);
    chk("rst_fw", finish_write, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    step();

    // Packet n=1, L=5; DRAW_DONE outside DRAW must be ignored
    start_session();
    chk("busy_session", busy, 1'b1);
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    chk("done_outside_draw_fw", finish_write, 1'b0);
    chk("done_outside_draw_busy", busy, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h0D, 1'b1);
    chk("pkt1_regs", regs, {96'h0, 40'h0D0C0B0A01});
    chk("pkt1_fr_count", fr_cnt, 1);

    // ENB pause in DRAW, then completion
    enb = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("enb_low_draw_go", draw_go, 1'b0);
    chk("enb_low_busy", busy, 1'b1);
    enb = 1'b1;
    #1;
    chk("enb_high_draw_go", draw_go, 1'b1);
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    chk("fw_pulse", finish_write, 1'b1);
    chk("idle_after_draw", busy, 1'b0);
    step();
    chk("fw_pulse_end", finish_write, 1'b0);

    // NOP header followed by n=3, L=9 packet
    start_session();
    send_byte(8'h00, 1'b0);
    chk("nop_reg0", regs[7:0], 8'h00);
    chk("nop_fr_count", fr_cnt, 1);
    chk("nop_busy", busy, 1'b1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b1);
    chk("pkt2_regs", regs, {64'h0, 72'h887766554433221103});
    chk("pkt2_fr_count", fr_cnt, 2);
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    chk("pkt2_fw", finish_write, 1'b1);
    step();

    // VALID held high for 20 cycles captures exactly one byte
    start_session();
    send_byte(8'h02, 1'b0);
    rbyte = 8'h5A;
    valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    valid = 1'b0;
    step();
    rbyte = 8'h00;
    chk("held_reg1", regs[15:8], 8'h5A);
    send_byte(8'h6B, 1'b0);
    chk("held_reg2", regs[23:16], 8'h6B);
    chk("held_reg3_old", regs[31:24], 8'h33);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b1);
    chk("pkt3_regs", regs[55:0], 56'hC4C3C2C16B5A02);
    chk("pkt3_fr_count", fr_cnt, 3);
    chk("err_default", err, 1'b0);

    // Asynchronous reset while in DRAW
    chk("pre_rst_draw_go", draw_go, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_regs", regs, '0);
    chk("midrst_draw_go", draw_go, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
